multicycle_cpu: RTL
===================

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set register, ALU, address and data width; legal values are 16 and above.
REQ-002 Parameter NREGS, default 8, SHALL set the register count; fixed at 8 because register fields are 3 bits.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-005 Port o_mem_addr, output, DATA_W, SHALL carry the byte address of the current memory request.
REQ-006 Port o_mem_rd, output, 1, SHALL be the read request strobe.
REQ-007 Port o_mem_wr, output, 1, SHALL be the write request strobe.
REQ-008 Port o_mem_wrdata, output, DATA_W, SHALL carry the store data.
REQ-009 Port i_mem_waitrequest, input, 1, SHALL mean the memory is stalling: while it is high, the CPU holds the request and all its outputs stable.
REQ-010 Port i_mem_rddata, input, DATA_W, SHALL carry read data; bits [15:0] form the instruction.
REQ-011 Port i_mem_rddatavalid, input, 1, SHALL mark i_mem_rddata valid, at least 1 cycle after the read is accepted.
REQ-012 Port o_halted, output, 1, SHALL be high while the core is in HALT.

Function
REQ-013 Instruction fields SHALL be:
- op = [3:0]
- i = [4]
- Rx = [7:5]
- Ry = [10:8]
- imm8 = [15:8], sign-extended
- imm11 = [15:5], sign-extended
REQ-014 Opcodes SHALL be:
- 0 mv: Rx <- B
- 1 add: Rx <- Rx+B
- 2 sub: Rx <- Rx-B
- 3 cmp: Rx-B, flags only
- 4 ld: Rx <- mem[Ry]
- 5 st: mem[Ry] <- Rx
- 6 mvhi: Rx[15:8] <- imm8, other bits kept
- 8 j, 9 jz, 10 jn, 12 call: call also writes R7 <- pc+2
- 15 halt
- B = Ry if i=0, else imm8
REQ-015 Jump target SHALL be Rx when i=0, and pc+2+2*imm11 when i=1; jz and jn are taken only when Z or N respectively is 1.
REQ-016 Z and N SHALL be updated only by add, sub and cmp; arithmetic is modulo 2^DATA_W.
REQ-017 FSM states SHALL be FETCH, FETCH_WAIT, EXEC, MEM, MEM_WAIT, HALT.
REQ-018 FETCH SHALL drive o_mem_rd=1 with o_mem_addr=pc, and go to FETCH_WAIT on the first cycle with i_mem_waitrequest=0.
REQ-019 FETCH_WAIT SHALL latch bits [15:0] into the IR when i_mem_rddatavalid=1, then go to EXEC.
REQ-020 EXEC SHALL complete ALU, mv, mvhi, cmp, jump and call in one cycle: register write-back and pc update occur at the end of EXEC, then the FSM goes to FETCH. ld and st go to MEM.
REQ-021 MEM SHALL assert o_mem_rd (ld) or o_mem_wr (st) with o_mem_addr=Ry.
- st: on acceptance, pc <- pc+2, next state FETCH.
- ld: on acceptance, next state MEM_WAIT.
REQ-022 MEM_WAIT SHALL write i_mem_rddata to Rx and set pc <- pc+2 when i_mem_rddatavalid=1, then go to FETCH.
REQ-023 Minimum cycles per instruction with zero-wait memory SHALL be 3 for ALU and jump, 4 for st, and 5 for ld.
REQ-024 Opcodes 7, 11, 13, 14 and 15 SHALL enter HALT. HALT issues no requests and is left only by reset.
REQ-025 At most one memory request SHALL be outstanding; i_mem_rddatavalid outside FETCH_WAIT or MEM_WAIT SHALL be ignored.
REQ-026 o_mem_rd and o_mem_wr SHALL never be high in the same cycle.
REQ-027 pc SHALL wrap modulo 2^DATA_W.

Reset
REQ-028 Reset SHALL set:
- pc = 0
- all registers = 0
- Z = N = 0
- IR = 0
- state = FETCH
REQ-029 During reset, o_mem_rd, o_mem_wr, o_halted = 0, and o_mem_addr, o_mem_wrdata = 0.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request. The first fetch from address 0 SHALL be issued the cycle after reset falls.

Structure
REQ-031 Package multicycle_cpu_pkg SHALL hold the opcode enum, the FSM state enum and the instruction field bit positions.
REQ-032 The register file SHALL be a sub-module, multicycle_cpu_regfile: 2 read ports, 1 write port, DATA_W wide, synchronous write, reset to zero.

Verification
REQ-033 Program mv R1,#5; add R1,#-7; jn +1 -> R1=0xFFFE, N=1, the jump is taken, and the instruction after the jump is skipped.
REQ-034 st R2->[R3] then ld R4<-[R3], with R2=0x1234 and R3=0x0040 -> wr at 0x0040 with data 0x1234, then R4=0x1234.
REQ-035 Hold i_mem_waitrequest=1 for 3 cycles and delay rddatavalid by 4 cycles -> o_mem_addr and o_mem_rd stay stable and the IR is correct.
REQ-036 call with i=1, imm11=3 at pc=0x0010 -> R7=0x0012 and pc=0x0018.
REQ-037 Reset asserted in MEM_WAIT, with a stale rddatavalid after reset -> registers stay 0 and the first fetch is from 0x0000.
REQ-038 Opcode 15 -> o_halted=1 and no further o_mem_rd or o_mem_wr until reset; repeat with DATA_W=32.

Source files
------------

// File: rtl/multicycle_cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states and
// instruction field positions.
package multicycle_cpu_pkg;

   typedef enum logic [3:0] {
      OP_MV   = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_CMP  = 4'd3,
      OP_LD   = 4'd4,
      OP_ST   = 4'd5,
      OP_MVHI = 4'd6,
      OP_J    = 4'd8,
      OP_JZ   = 4'd9,
      OP_JN   = 4'd10,
      OP_CALL = 4'd12,
      OP_HALT = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      FETCH,
      FETCH_WAIT,
      EXEC,
      MEM,
      MEM_WAIT,
      HALT
   } state_e;

   localparam int OP_LSB    = 0;
   localparam int OP_MSB    = 3;
   localparam int I_BIT     = 4;
   localparam int RX_LSB    = 5;
   localparam int RX_MSB    = 7;
   localparam int RY_LSB    = 8;
   localparam int RY_MSB    = 10;
   localparam int IMM8_LSB  = 8;
   localparam int IMM8_MSB  = 15;
   localparam int IMM11_LSB = 5;
   localparam int IMM11_MSB = 15;
   localparam int LINK_REG  = 7;

endpackage

// File: rtl/multicycle_cpu_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// all registers cleared by the synchronous reset.
module multicycle_cpu_regfile #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [$clog2(NREGS)-1:0]   ra_addr,
   output logic [DATA_W-1:0]          ra_data,
   input  logic [$clog2(NREGS)-1:0]   rb_addr,
   output logic [DATA_W-1:0]          rb_data,
   input  logic                       wr_en,
   input  logic [$clog2(NREGS)-1:0]   wr_addr,
   input  logic [DATA_W-1:0]          wr_data
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign ra_data = regs_q[ra_addr];
   assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle 16-bit-instruction CPU with a single-outstanding-request
// memory port (waitrequest / rddatavalid handshake).
module multicycle_cpu
   import multicycle_cpu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              reset,
   output logic [DATA_W-1:0] o_mem_addr,
   output logic              o_mem_rd,
   output logic              o_mem_wr,
   output logic [DATA_W-1:0] o_mem_wrdata,
   input  logic              i_mem_waitrequest,
   input  logic [DATA_W-1:0] i_mem_rddata,
   input  logic              i_mem_rddatavalid,
   output logic              o_halted
);

   localparam int RA_W = $clog2(NREGS);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic              z_q, z_d;
   logic              n_q, n_d;

   opcode_e           op;
   logic              imm_sel;
   logic [RA_W-1:0]   rx, ry;
   logic [DATA_W-1:0] imm8_x, imm11_x, rx_val, ry_val, b_val;
   logic [DATA_W-1:0] pc_next, jmp_target, alu_res, mvhi_val;

   logic              rf_we;
   logic [RA_W-1:0]   rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   logic              mem_rd, mem_wr;
   logic [DATA_W-1:0] mem_addr, mem_wrdata;

   assign op      = opcode_e'(ir_q[OP_MSB:OP_LSB]);
   assign imm_sel = ir_q[I_BIT];
   assign rx      = ir_q[RX_MSB:RX_LSB];
   assign ry      = ir_q[RY_MSB:RY_LSB];
   assign imm8_x  = {{(DATA_W-8){ir_q[IMM8_MSB]}}, ir_q[IMM8_MSB:IMM8_LSB]};
   assign imm11_x = {{(DATA_W-11){ir_q[IMM11_MSB]}}, ir_q[IMM11_MSB:IMM11_LSB]};

   multicycle_cpu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .ra_addr (rx),
      .ra_data (rx_val),
      .rb_addr (ry),
      .rb_data (ry_val),
      .wr_en   (rf_we),
      .wr_addr (rf_waddr),
      .wr_data (rf_wdata)
   );

   assign b_val      = imm_sel ? imm8_x : ry_val;
   assign pc_next    = pc_q + DATA_W'(2);
   assign jmp_target = imm_sel ? (pc_next + {imm11_x[DATA_W-2:0], 1'b0}) : rx_val;

   always_comb begin
      alu_res  = ((op == OP_SUB) || (op == OP_CMP)) ? (rx_val - b_val) : (rx_val + b_val);
      mvhi_val = rx_val;
      mvhi_val[15:8] = ir_q[IMM8_MSB:IMM8_LSB];
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      z_d        = z_q;
      n_d        = n_q;
      rf_we      = 1'b0;
      rf_waddr   = rx;
      rf_wdata   = b_val;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wrdata = '0;

      case (state_q)
         FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = pc_q;
            if (!i_mem_waitrequest) begin
               state_d = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (i_mem_rddatavalid) begin
               ir_d    = i_mem_rddata[15:0];
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = FETCH;
            pc_d    = pc_next;
            case (op)
               OP_MV: rf_we = 1'b1;
               OP_ADD, OP_SUB: begin
                  rf_we    = 1'b1;
                  rf_wdata = alu_res;
                  z_d      = (alu_res == '0);
                  n_d      = alu_res[DATA_W-1];
               end
               OP_CMP: begin
                  z_d = (alu_res == '0);
                  n_d = alu_res[DATA_W-1];
               end
               OP_MVHI: begin
                  rf_we    = 1'b1;
                  rf_wdata = mvhi_val;
               end
               // Loads and stores advance the pc only once the access completes.
               OP_LD, OP_ST: begin
                  state_d = MEM;
                  pc_d    = pc_q;
               end
               OP_J:  pc_d = jmp_target;
               OP_JZ: pc_d = z_q ? jmp_target : pc_next;
               OP_JN: pc_d = n_q ? jmp_target : pc_next;
               OP_CALL: begin
                  rf_we    = 1'b1;
                  rf_waddr = RA_W'(LINK_REG);
                  rf_wdata = pc_next;
                  pc_d     = jmp_target;
               end
               default: begin
                  state_d = HALT;
                  pc_d    = pc_q;
               end
            endcase
         end
         MEM: begin
            mem_addr = ry_val;
            if (op == OP_ST) begin
               mem_wr     = 1'b1;
               mem_wrdata = rx_val;
               if (!i_mem_waitrequest) begin
                  pc_d    = pc_next;
                  state_d = FETCH;
               end
            end else begin
               mem_rd = 1'b1;
               if (!i_mem_waitrequest) begin
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            if (i_mem_rddatavalid) begin
               rf_we    = 1'b1;
               rf_wdata = i_mem_rddata;
               pc_d     = pc_next;
               state_d  = FETCH;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   // The state register already holds FETCH during reset, so the bus is forced quiet here.
   assign o_mem_rd     = mem_rd & ~reset;
   assign o_mem_wr     = mem_wr & ~reset;
   assign o_mem_addr   = reset ? '0 : mem_addr;
   assign o_mem_wrdata = reset ? '0 : mem_wrdata;
   assign o_halted     = (state_q == HALT) & ~reset;

endmodule
